instreg_hs: RTL

- Parametrised, handshaked instruction register between fetch and the execute/ALU datapath.
- Splits each instruction word into an opcode (ALU select) field and an operand field.
- Supports two-word instructions: the opcode MSB set means the next fetched word is a full-width immediate.
- Holds the decoded instruction until execute accepts it, and counts retired instructions.

---
 rtl/instreg_hs.sv | 115 +++++++++++
 1 files changed

// File: rtl/instreg_hs.sv
// Handshaked instruction register: splits fetched words into opcode/operand, supports two-word immediates,
// counts consumed instructions. Optional INSTREG_ILLEGAL_TRAP_EN adds an illegal-opcode trap output.
module instreg_hs #(
  parameter int OP_W    = 3,
  parameter int ARG_W   = 8,
  parameter int COUNT_W = 16,
  parameter logic [(2**OP_W)-1:0] LEGAL_MASK = '1,
  localparam int INST_W = OP_W + ARG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [INST_W-1:0]  inst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OP_W-1:0]    alu_sel,
  output logic [ARG_W-1:0]   a,
  output logic [INST_W-1:0]  imm,
  output logic               has_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] inst_count
`ifdef INSTREG_ILLEGAL_TRAP_EN
  ,
  output logic               illegal
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXT  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t            state_r;
  logic [OP_W-1:0]   op_s;
  logic [ARG_W-1:0]  arg_s;
  logic              legal_s;
  logic              accept_s;
  logic              load_first_s;
  logic              consume_s;
  logic              illegal_r;

  assign op_s  = inst[INST_W-1 -: OP_W];
  assign arg_s = inst[ARG_W-1:0];

  assign in_ready     = !rst && ((state_r != S_FULL) || out_ready);
  assign accept_s     = in_valid && in_ready && !flush;
  assign load_first_s = accept_s && (state_r != S_EXT);
  assign consume_s    = out_valid && out_ready;

`ifdef INSTREG_ILLEGAL_TRAP_EN
  assign legal_s = LEGAL_MASK[op_s];
  assign illegal = illegal_r;
`else
  // Mask is ignored in this build: every opcode is legal.
  assign legal_s = 1'b1 | LEGAL_MASK[op_s];
`endif

  // Decode FSM, latched fields and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      out_valid  <= 1'b0;
      alu_sel    <= '0;
      a          <= '0;
      imm        <= '0;
      has_imm    <= 1'b0;
      illegal_r  <= 1'b0;
      inst_count <= '0;
    end else if (flush) begin
      // Data registers keep their values; only the handshake state is dropped.
      state_r   <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      if (consume_s && !illegal_r) begin
        inst_count <= inst_count + COUNT_W'(1);
      end
      case (state_r)
        S_IDLE, S_FULL: begin
          if (load_first_s) begin
            alu_sel   <= op_s;
            a         <= arg_s;
            illegal_r <= !legal_s;
            if (op_s[OP_W-1] && legal_s) begin
              has_imm   <= 1'b1;
              state_r   <= S_EXT;
              out_valid <= 1'b0;
            end else begin
              has_imm   <= 1'b0;
              imm       <= '0;
              state_r   <= S_FULL;
              out_valid <= 1'b1;
            end
          end else if ((state_r == S_FULL) && out_ready) begin
            state_r   <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        S_EXT: begin
          if (accept_s) begin
            imm       <= inst;
            state_r   <= S_FULL;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
